// File: rtl/tdc_hit_encoder.sv
// tdc_hit_encoder: turns filtered hit strobes plus delay-line taps into
// {bubble, coarse, fine} timestamps and buffers them in a show-ahead FIFO.
`timescale 1ns/1ps

module tdc_hit_encoder #(
    parameter int NTAPS    = 64,
    parameter int FINE_W   = 7,
    parameter int COARSE_W = 24,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [NTAPS-1:0]           thermo_in,
    output logic [COARSE_W+FINE_W:0]   ts_data,
    output logic                       ts_valid,
    input  logic                       ts_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    output logic                       coarse_wrap
);

    localparam int W     = 1 + COARSE_W + FINE_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Front end: coarse counter, wrap pulse, rising-edge hit detector
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic                wrap_q, wrap_d;
    logic                valid_prev_q, valid_prev_d;
    logic                hit;

    // Stage 1: captured taps and coarse time of the hit
    logic                s1_valid_q, s1_valid_d;
    logic [NTAPS-1:0]    s1_thermo_q, s1_thermo_d;
    logic [COARSE_W-1:0] s1_coarse_q, s1_coarse_d;

    // Stage 2: encoded word waiting for the FIFO write
    logic                s2_valid_q, s2_valid_d;
    logic [W-1:0]        s2_word_q, s2_word_d;
    logic [FINE_W-1:0]   fine;
    logic                bubble;

    // FIFO
    logic [W-1:0]        mem_q [DEPTH];
    logic [W-1:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_count_q, drop_count_d;
    logic                full, empty, pop, push, drop;

    // Next-state for the free-running counter, hit detector and stage 1
    always_comb begin
        coarse_d     = coarse_q + COARSE_W'(1);
        wrap_d       = &coarse_q;
        hit          = valid_in & ~valid_prev_q;
        valid_prev_d = valid_in;
        s1_valid_d   = hit;
        s1_thermo_d  = hit ? thermo_in : s1_thermo_q;
        s1_coarse_d  = hit ? coarse_q  : s1_coarse_q;
    end

    // Stage 2 encode: popcount fine code, bubble = a one above a zero
    always_comb begin
        fine   = '0;
        bubble = 1'b0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            fine = fine + FINE_W'(s1_thermo_q[i]);
        end
        for (int unsigned i = 1; i < NTAPS; i++) begin
            if (s1_thermo_q[i] && !s1_thermo_q[i-1]) begin
                bubble = 1'b1;
            end
        end
        s2_valid_d = s1_valid_q;
        s2_word_d  = s1_valid_q ? {bubble, s1_coarse_q, fine} : s2_word_q;
    end

    // FIFO control; a pop frees the slot a same-cycle write lands in, so a full FIFO never drops then
    always_comb begin
        full         = (level_q == LVL_W'(DEPTH));
        empty        = (level_q == '0);
        pop          = !empty && ts_ready;
        push         = s2_valid_q && (!full || pop);
        drop         = s2_valid_q && full && !pop;
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d      = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
        overflow_d   = overflow_q | drop;
        drop_count_d = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
        mem_d        = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = s2_word_q;
        end
    end

    // Control and pipeline registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse_q     <= '0;
            wrap_q       <= 1'b0;
            valid_prev_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_thermo_q  <= '0;
            s1_coarse_q  <= '0;
            s2_valid_q   <= 1'b0;
            s2_word_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            coarse_q     <= coarse_d;
            wrap_q       <= wrap_d;
            valid_prev_q <= valid_prev_d;
            s1_valid_q   <= s1_valid_d;
            s1_thermo_q  <= s1_thermo_d;
            s1_coarse_q  <= s1_coarse_d;
            s2_valid_q   <= s2_valid_d;
            s2_word_q    <= s2_word_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // FIFO storage; contents are only visible through the level-qualified head
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Output mapping; head word is forced to zero while empty so reset reads as 0
    always_comb begin
        ts_valid    = !empty;
        ts_data     = empty ? '0 : mem_q[rd_ptr_q];
        fifo_level  = level_q;
        overflow    = overflow_q;
        drop_count  = drop_count_q;
        coarse_wrap = wrap_q;
    end

endmodule

// File: doc/tdc_hit_encoder.md
Name: tdc_hit_encoder

Overview:
Downstream neighbour of the hit input filter. It consumes the filter's one-cycle `valid` strobe and the delay-line tap vector sampled on `clk`, and builds a timestamp for each hit. The timestamp is a free-running coarse count plus a bubble-tolerant fine code from the thermometer taps. Timestamps are buffered in a small FIFO with a valid/ready read interface toward the readout logic.

Parameters:
NTAPS, 64, number of delay-line taps in the thermometer vector
FINE_W, 7, fine-code width; must equal clog2(NTAPS+1)
COARSE_W, 24, coarse counter width
DEPTH, 8, FIFO depth in words; power of two, at least 2

Ports:
clk  in  1  system clock, the same clock as the input filter
rst_n  in  1  reset; asynchronous, active-low
valid_in  in  1  hit strobe from the input filter
thermo_in  in  NTAPS  delay-line taps, already registered on clk, bit 0 is the first tap
ts_data  out  1+COARSE_W+FINE_W  {bubble, coarse, fine} at FIFO head
ts_valid  out  1  FIFO not empty
ts_ready  in  1  consumer accepts ts_data when ts_valid and ts_ready are both high
fifo_level  out  clog2(DEPTH)+1  words currently stored
overflow  out  1  sticky, set when a hit is dropped
drop_count  out  8  hits dropped, saturates at 255
coarse_wrap  out  1  one-cycle pulse when the coarse counter wraps

Behaviour:
- Reset, asynchronous and active-low:
  - coarse = 0, pipeline valids = 0, FIFO empty.
  - ts_data = 0, ts_valid = 0, fifo_level = 0.
  - overflow = 0, drop_count = 0, coarse_wrap = 0.
  - Edge detector armed, with the previous valid_in state taken as 0.
- Coarse counter:
  - Free-running, +1 per clk.
  - Wraps from 2^COARSE_W-1 to 0.
  - coarse_wrap is high for the single cycle in which coarse is 0 after a wrap. It is not asserted on the first cycle after reset.
- Hit detection:
  - A hit is a valid_in cycle where valid_in=1 and the previous cycle's valid_in=0.
  - valid_in held high for N cycles yields exactly one hit.
  - Re-arms after at least one low cycle.
- Stage 1, at the hit cycle edge: register thermo_in and the current coarse value (call it C).
- Stage 2, one cycle later:
  - fine = popcount(thermo_s1), range 0..NTAPS, unsigned, FINE_W bits.
  - bubble = 1 if any i in 1..NTAPS-1 has thermo_s1[i]=1 and thermo_s1[i-1]=0. The fine code is still the popcount in that case.
  - Word {bubble, C, fine} is presented for FIFO write.
- Latency:
  - Hit sampled at edge k → word written at edge k+2 → ts_valid high after edge k+2, provided the FIFO was empty.
  - No bypass of the FIFO.
- FIFO:
  - Show-ahead: ts_data always reflects the head word while ts_valid=1. ts_data contents are don't-care when empty; the reset value is 0.
  - Read pops on ts_valid & ts_ready.
  - Write when full: word dropped, overflow set (sticky until reset), drop_count increments, saturating at 255.
  - Simultaneous pop and write when full: both succeed, level unchanged, no drop.
  - Simultaneous pop and write at other levels: level unchanged.
  - Pointers wrap modulo DEPTH. fifo_level tracks 0..DEPTH exactly.
- Back-to-back hits:
  - Minimum hit spacing is 2 cycles (high, low, high). Every such hit produces a word.
  - Pipeline stages are independent, so no hit is lost inside the pipeline.
- ts_ready is ignored while ts_valid=0.
- Reset asserted mid-operation:
  - Pipeline and FIFO contents are discarded immediately.
  - No word is emitted after deassertion unless a new hit arrives.

Test Plan:
- Single hit, no bubble: after reset, wait for coarse=100, assert valid_in for 1 cycle with thermo_in=64'h00000000000000FF. Required: 2 edges later, ts_valid=1 and ts_data={0, 24'd100, 7'd8}; after one ts_ready cycle, ts_valid=0 and fifo_level=0.
- Bubble: thermo_in=64'h00000000000000F7. Required: word has bubble=1 and fine=7. Also thermo all-ones gives fine=64, bubble=0; thermo all-zeros gives fine=0, bubble=0.
- Held strobe: valid_in high for 5 cycles. Required: exactly one word, fifo_level=1. Then a low/high pattern of 1010101 gives 4 words whose coarse values are 2 apart.
- Overflow: ts_ready=0, 10 hits spaced 2 cycles apart. Required: fifo_level=8, overflow=1, drop_count=2, and the 8 stored words hold the first 8 coarse values in order. With 300 hits, drop_count=255.
- Full with concurrent read: FIFO full, ts_ready=1 in the same cycle a new word writes. Required: no drop, fifo_level stays 8, drop_count unchanged.
- Wrap and reset:
  - With COARSE_W=4, coarse_wrap pulses every 16 cycles, and a hit at coarse=15 records 15.
  - Assert rst_n=0 one cycle after a hit. Required: all outputs return to 0 and no word appears after release.
